// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if
// Groups the keypad matrix pins and the accepted-key outputs of the scanner.
// Signals:
//   row_sense  - raw matrix rows, active-low, asynchronous to the scanner clock
//   col_drive  - column strobe, active-low, one bit low at a time
//   keypad_row - one-hot row of the held key (0 when none)
//   keypad_col - one-hot column of the held key (0 when none)
//   key_code   - key number row*4+col
//   key_valid  - one-cycle pulse per accepted press (and per repeat)
//   key_held   - high while an accepted key is held
//   multi_key  - last completed scan saw more than one key
// Modports: master = scanner side, slave = keypad/consumer side.
`timescale 1ns/1ps

interface keypad_matrix_scanner_if;
    logic [3:0] row_sense;
    logic [3:0] col_drive;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    modport master (
        input  row_sense,
        output col_drive, keypad_row, keypad_col, key_code,
        output key_valid, key_held, multi_key
    );

    modport slave (
        output row_sense,
        input  col_drive, keypad_row, keypad_col, key_code,
        input  key_valid, key_held, multi_key
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Strobes the 4x4 keypad columns, samples the rows through a 2-flop
// synchroniser, debounces single key presses and presents the accepted key
// as one-hot row/column plus a key number.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - keypad_matrix_scanner_if.master (matrix pins and key outputs)
// Parameters:
//   SCAN_DIV       - clocks per column slot (4..65535)
//   DEBOUNCE_SCANS - identical full scans to accept or release (1..15)
//   REPEAT_SCANS   - auto-repeat interval in full scans (1..255)
// Optional feature: define KEYPAD_SCAN_REPEAT_EN to enable auto-repeat of
// key_valid while a key stays held.
`timescale 1ns/1ps

module keypad_matrix_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    keypad_matrix_scanner_if.master        bus
);
    localparam int unsigned SLOT_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned KEYS   = 16;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

    state_t            state;
    logic [3:0]        sync1, sync2;
    logic [3:0]        rows;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        col_idx;
    logic [1:0]        next_col;
    logic [KEYS-1:0]   snap, snap_sample, scan_snap;
    logic              scan_done;
    logic [4:0]        snap_cnt;
    logic [3:0]        snap_idx;
    logic              is_single, is_multi;
    logic [3:0]        cand;
    logic [CNT_W-1:0]  deb, rel, deb_sat, rel_sat;
    logic              accept;

    // Row synchroniser; idles at the pulled-up level so reset reads no key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= bus.row_sense;
            sync2 <= sync1;
        end
    end

    assign rows     = ~sync2;
    assign next_col = col_idx + 2'd1;

    // Current column's rows placed at bit row*4+col
    always_comb begin
        snap_sample = '0;
        for (int r = 0; r < 4; r++) begin
            snap_sample[r*4 + int'(col_idx)] = rows[r];
        end
    end

    // Column strobe and snapshot; a full snapshot is handed off at scan end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt      <= '0;
            col_idx       <= '0;
            bus.col_drive <= 4'b1110;
            snap          <= '0;
            scan_snap     <= '0;
            scan_done     <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt      <= '0;
                col_idx       <= next_col;
                bus.col_drive <= ~(4'b0001 << next_col);
                if (col_idx == 2'd3) begin
                    scan_snap <= snap | snap_sample;
                    snap      <= '0;
                    scan_done <= 1'b1;
                end else begin
                    snap <= snap | snap_sample;
                end
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Snapshot classification: key count and index of the (last) set bit
    always_comb begin
        snap_cnt = '0;
        snap_idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (scan_snap[i]) begin
                snap_cnt = snap_cnt + 5'd1;
                snap_idx = 4'(i);
            end
        end
    end

    assign is_single = (snap_cnt == 5'd1);
    assign is_multi  = (snap_cnt > 5'd1);
    assign deb_sat   = (deb == '1) ? deb : deb + CNT_W'(1);
    assign rel_sat   = (rel == '1) ? rel : rel + CNT_W'(1);

    // Accept either straight from IDLE (single-scan debounce) or on reaching the count
    assign accept = scan_done && is_single &&
                    (((state == IDLE) && (DEB_TARGET == CNT_W'(1))) ||
                     ((state == DEBOUNCE) && (snap_idx == cand) && (deb_sat >= DEB_TARGET)));

`ifdef KEYPAD_SCAN_REPEAT_EN
    localparam int unsigned REP_W = 8;
    localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep, rep_sat;
    assign rep_sat = (rep == '1) ? rep : rep + REP_W'(1);
`endif

    // Debounce / hold FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cand           <= '0;
            deb            <= '0;
            rel            <= '0;
            bus.keypad_row <= '0;
            bus.keypad_col <= '0;
            bus.key_code   <= '0;
            bus.key_valid  <= 1'b0;
            bus.key_held   <= 1'b0;
            bus.multi_key  <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
            rep            <= '0;
`endif
        end else begin
            bus.key_valid <= 1'b0;
            if (scan_done) begin
                bus.multi_key <= is_multi;
                if (accept) begin
                    state          <= HELD;
                    cand           <= snap_idx;
                    deb            <= deb_sat;
                    rel            <= '0;
                    bus.key_valid  <= 1'b1;
                    bus.keypad_row <= 4'b0001 << snap_idx[3:2];
                    bus.keypad_col <= 4'b0001 << snap_idx[1:0];
                    bus.key_code   <= snap_idx;
                    bus.key_held   <= 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
                    rep            <= '0;
`endif
                end else begin
                    case (state)
                        IDLE: begin
                            if (is_single) begin
                                cand  <= snap_idx;
                                deb   <= CNT_W'(1);
                                state <= DEBOUNCE;
                            end
                        end
                        DEBOUNCE: begin
                            if (is_single && (snap_idx == cand)) begin
                                deb <= deb_sat;
                            end else if (is_single) begin
                                cand <= snap_idx;
                                deb  <= CNT_W'(1);
                            end else begin
                                state <= IDLE;
                                deb   <= '0;
                            end
                        end
                        HELD: begin
                            // Extra keys alongside the held one are ignored
                            if (scan_snap[cand]) begin
                                rel <= '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                if (rep_sat >= REP_TARGET) begin
                                    bus.key_valid <= 1'b1;
                                    rep           <= '0;
                                end else begin
                                    rep <= rep_sat;
                                end
`endif
                            end else begin
                                rel <= rel_sat;
`ifdef KEYPAD_SCAN_REPEAT_EN
                                rep <= '0;
`endif
                                if (rel_sat >= DEB_TARGET) begin
                                    state          <= IDLE;
                                    deb            <= '0;
                                    bus.keypad_row <= '0;
                                    bus.keypad_col <= '0;
                                    bus.key_code   <= '0;
                                    bus.key_held   <= 1'b0;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one scan = 16 cycles). A matrix model pulls a row low when a pressed key's
// column is strobed. Cycle 0 is the cycle in which reset is released.
// Optional feature macro: KEYPAD_SCAN_REPEAT_EN (REPEAT_SCANS=3).
`timescale 1ns/1ps

module tb_keypad_matrix_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pcnt = 0;
    int          base = 0;
    bit          rep_en;

    keypad_matrix_scanner_if bus ();

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Matrix model: row low when a pressed key sits on the driven column
    always_comb begin
        bus.row_sense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !bus.col_drive[c]) bus.row_sense[r] = 1'b0;
            end
        end
    end

    // Pulse counter; each one-cycle pulse is seen at exactly one rising edge
    always @(posedge clk) if (bus.key_valid) pcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic restart(input logic [15:0] keys);
        @(negedge clk);
        reset   = 1'b1;
        pressed = '0;
        repeat (2) @(negedge clk);
        pressed = keys;
        reset   = 1'b0;
        cyc     = 0;
        base    = pcnt;
    endtask

    initial begin
`ifdef KEYPAD_SCAN_REPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif
        // Idle scan: column strobe sequence, all outputs quiet
        restart(16'h0000);
        check("reset_col_drive", 32'(bus.col_drive), 32'h0E);
        check("reset_row", 32'(bus.keypad_row), 0);
        check("reset_col", 32'(bus.keypad_col), 0);
        check("reset_code", 32'(bus.key_code), 0);
        check("reset_valid", 32'(bus.key_valid), 0);
        check("reset_held", 32'(bus.key_held), 0);
        check("reset_multi", 32'(bus.multi_key), 0);
        tick_to(3);  check("col_c3", 32'(bus.col_drive), 32'h0E);
        tick_to(4);  check("col_c4", 32'(bus.col_drive), 32'h0D);
        tick_to(8);  check("col_c8", 32'(bus.col_drive), 32'h0B);
        tick_to(12); check("col_c12", 32'(bus.col_drive), 32'h07);
        tick_to(16); check("col_c16", 32'(bus.col_drive), 32'h0E);
        tick_to(40);
        check("idle_no_pulse", 32'(pcnt - base), 0);
        check("idle_held", 32'(bus.key_held), 0);

        // Key 6 (row 1, col 2) from a scan boundary, release on a boundary
        restart(16'h0040);
        tick_to(32);
        check("k6_valid_c32", 32'(bus.key_valid), 0);
        check("k6_held_c32", 32'(bus.key_held), 0);
        tick_to(33);
        check("k6_valid_c33", 32'(bus.key_valid), 1);
        check("k6_row", 32'(bus.keypad_row), 32'h2);
        check("k6_col", 32'(bus.keypad_col), 32'h4);
        check("k6_code", 32'(bus.key_code), 6);
        check("k6_held", 32'(bus.key_held), 1);
        tick_to(34);
        check("k6_valid_c34", 32'(bus.key_valid), 0);
        check("k6_held_c34", 32'(bus.key_held), 1);
        tick_to(48);
        pressed = '0;
        tick_to(80);
        check("k6_rel_held_c80", 32'(bus.key_held), 1);
        tick_to(81);
        check("k6_rel_held_c81", 32'(bus.key_held), 0);
        check("k6_rel_row", 32'(bus.keypad_row), 0);
        check("k6_rel_col", 32'(bus.keypad_col), 0);
        check("k6_rel_code", 32'(bus.key_code), 0);
        check("k6_pulses", 32'(pcnt - base), 1);

        // Key 6 switched to key 9 during the second scan
        restart(16'h0040);
        tick_to(20);
        pressed = 16'h0200;
        tick_to(48);
        check("sw_no_pulse", 32'(pcnt - base), 0);
        check("sw_held_c48", 32'(bus.key_held), 0);
        tick_to(49);
        check("sw_valid", 32'(bus.key_valid), 1);
        check("sw_code", 32'(bus.key_code), 9);
        check("sw_row", 32'(bus.keypad_row), 32'h4);
        check("sw_col", 32'(bus.keypad_col), 32'h2);
        tick_to(60);
        check("sw_pulses", 32'(pcnt - base), 1);

        // Keys 0 and 5 together: multi, never accepted
        restart(16'h0021);
        tick_to(16); check("mk_multi_c16", 32'(bus.multi_key), 0);
        tick_to(17); check("mk_multi_c17", 32'(bus.multi_key), 1);
        tick_to(60);
        check("mk_no_pulse", 32'(pcnt - base), 0);
        check("mk_held", 32'(bus.key_held), 0);
        check("mk_multi_c60", 32'(bus.multi_key), 1);
        tick_to(64);
        pressed = '0;
        tick_to(80); check("mk_multi_c80", 32'(bus.multi_key), 1);
        tick_to(81); check("mk_multi_c81", 32'(bus.multi_key), 0);

        // Reset mid-press clears outputs asynchronously; key re-debounced
        restart(16'h0040);
        tick_to(40);
        check("rst_held_before", 32'(bus.key_held), 1);
        reset = 1'b1;
        #1;
        check("rst_async_held", 32'(bus.key_held), 0);
        check("rst_async_row", 32'(bus.keypad_row), 0);
        check("rst_async_col", 32'(bus.keypad_col), 0);
        check("rst_async_code", 32'(bus.key_code), 0);
        check("rst_async_coldrv", 32'(bus.col_drive), 32'h0E);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        tick_to(32);
        check("rst_valid_c32", 32'(bus.key_valid), 0);
        check("rst_held_c32", 32'(bus.key_held), 0);
        tick_to(33);
        check("rst_valid_c33", 32'(bus.key_valid), 1);
        check("rst_code", 32'(bus.key_code), 6);

        // Key 3 held for 10 scans after accept: repeats only when enabled
        restart(16'h0008);
        tick_to(33);
        check("rep_accept", 32'(bus.key_valid), 1);
        check("rep_code", 32'(bus.key_code), 3);
        tick_to(80);
        check("rep_valid_c80", 32'(bus.key_valid), 0);
        tick_to(81);
        check("rep_valid_c81", 32'(bus.key_valid), rep_en ? 1 : 0);
        tick_to(195);
        check("rep_pulses", 32'(pcnt - base), rep_en ? 4 : 1);
        check("rep_held", 32'(bus.key_held), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Physical front end for the 4x4 parameter keypad. It strobes the matrix columns and samples the row lines through a synchroniser. It debounces and validates single key presses, then presents the accepted key to the keypad parameter-entry stage as one-hot `keypad_row`/`keypad_col`. That stage reads these outputs directly; no decoding is needed downstream.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clocks per column slot. Legal range 4..65535.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept or release a key. Legal range 1..15.
- `REPEAT_SCANS`, default 32: auto-repeat interval in full scans. Legal range 1..255. Used only with `KEYPAD_SCAN_REPEAT_EN`.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `row_sense`, in, 4: raw matrix rows, active-low with pull-ups. Asynchronous to `clk`.
- `col_drive`, out, 4: column strobe, active-low. Exactly one bit is low at any time.
- `keypad_row`, out, 4: one-hot row of the held key; 0 when no key is held.
- `keypad_col`, out, 4: one-hot column of the held key; 0 when no key is held.
- `key_code`, out, 4: key number, computed as row*4+col.
- `key_valid`, out, 1: one-cycle pulse for each accepted press (and each repeat).
- `key_held`, out, 1: high while an accepted key is held.
- `multi_key`, out, 1: high when the last completed scan saw more than one key.

## Operation
Synchroniser:
- `row_sense` passes through a 2-flop synchroniser.
- The synchroniser outputs are inverted to active-high.

Scan counter:
- `slot_cnt` counts 0..SCAN_DIV-1.
- `col_idx` counts 0..3 and advances when `slot_cnt` wraps.
- `col_drive = ~(1<<col_idx)`.

Sampling and snapshot:
- Rows are sampled only at `slot_cnt==SCAN_DIV-1`. This allows settling plus synchroniser delay.
- Each sample is written into a 16-bit snapshot: bit index is row*4+col.
- A scan ends at the sample of `col_idx==3`.
- At scan end the snapshot is classified as NONE (0 bits set), SINGLE(k) (exactly 1 bit), or MULTI (2 or more bits).
- The snapshot is then cleared.

FSM states and transitions:
- **IDLE**
  - SINGLE(k): set `cand=k`, `deb=1`, go to DEBOUNCE. If `DEBOUNCE_SCANS==1`, accept immediately.
  - NONE or MULTI: stay in IDLE.
- **DEBOUNCE**
  - SINGLE(cand): increment `deb`. When `deb` reaches `DEBOUNCE_SCANS`, accept.
  - SINGLE(other key): set `cand` to the new key, `deb=1`.
  - NONE or MULTI: go to IDLE, `deb=0`.
- **Accept** (action, not a state)
  - Pulse `key_valid` for one cycle.
  - Load `keypad_row`, `keypad_col` and `key_code` from `cand`.
  - Set `key_held=1`, `rel=0`, `rep=0`.
  - Go to HELD.
- **HELD**
  - Snapshot contains `cand` (extra keys are ignored): `rel=0`.
  - Snapshot lacks `cand`: increment `rel`. When `rel` reaches `DEBOUNCE_SCANS`, clear `keypad_row`, `keypad_col`, `key_code` and `key_held`, and go to IDLE.

`multi_key`:
- Updated at every scan end in every state: set to 1 if the scan was MULTI, else 0.
- It is never a reason to accept a key.

## Timing
Reset values (asynchronous):
- `col_drive=4'b1110`.
- All other outputs 0.
- `slot_cnt=0`, `col_idx=0`, FSM in IDLE, snapshot cleared.
- Reset asserted mid-press drops all outputs immediately. After release of reset, the key must be re-debounced from scratch.

Scan timing:
- One full scan takes 4*SCAN_DIV cycles.
- Classification, FSM update and all output updates occur on the clock edge one cycle after the scan-end sample cycle.
- `key_valid` is high for exactly that one cycle.

Latencies:
- Press, stable from before a scan start, to `key_valid`: DEBOUNCE_SCANS scans plus 1 cycle.
- Release to outputs cleared: DEBOUNCE_SCANS scans plus 1 cycle.

Boundary conditions:
- A bounce within one scan makes that scan's snapshot mismatch, which restarts the count.
- `deb`, `rel` and `rep` saturate and never wrap.

## Configuration
Macro `KEYPAD_SCAN_REPEAT_EN`:
- Defined: in HELD, `rep` increments on every scan that contains `cand`.
  - When `rep` reaches `REPEAT_SCANS`, `key_valid` pulses again and `rep=0`.
  - A release scan (one lacking `cand`) clears `rep`.
- Undefined: the `rep` logic is absent and `key_valid` pulses exactly once per accepted press.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles. The bench models the matrix: a row reads low when the pressed key's column is driven low.
- Reset, then idle -> `col_drive` sequence 1110, 1101, 1011, 0111, changing every 4 cycles. Outputs stay 0.
- Hold row 1 / col 2 from a scan boundary -> one `key_valid` pulse at cycle 33 after the scan boundary, with `keypad_row=0010`, `keypad_col=0100`, `key_code=6`, `key_held=1`. Release -> outputs return to 0 after 2 empty scans plus 1 cycle.
- Press key 6, then switch to key 9 during the second scan -> no pulse for key 6. A single pulse for key 9 (`key_code=9`) follows 2 full stable scans later.
- Hold keys 0 and 5 together -> `multi_key=1` after the first scan, no `key_valid`, `key_held=0`.
- Key 6 accepted, then `reset` pulsed for 1 cycle -> all outputs 0 asynchronously. With the key still held, a new `key_valid` appears 2 scans plus 1 cycle after reset deassertion.
- With `KEYPAD_SCAN_REPEAT_EN` and REPEAT_SCANS=3: accept key 3 and hold it for 10 further scans -> 4 `key_valid` pulses in total (the accept pulse plus repeats at scans 3, 6 and 9 of HELD).
